mem_initiator: RTL and testbench
================================

# mem_initiator

Command-driven initiator for the picorv32 native memory interface (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata). It accepts one load/store command at a time, converts it to a single word-aligned bus transaction with byte strobes, and returns extracted and extended load data. A per-transaction watchdog ends the transaction if no responder answers. It stands in for the CPU core when driving the testbench memory/console responder and its mutated variants directly.

## Interface
- TIMEOUT_CYCLES, 10000: maximum cycles mem_valid is held awaiting mem_ready; legal range 1 to 2^20.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted; high only in IDLE.
- cmd_write  in  1  1 = store, 0 = load.
- cmd_instr  in  1  forwarded to mem_instr; loads only.
- cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- cmd_signed  in  1  sign-extend load data; ignored for word loads and stores.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal size, or timeout.
- mem_valid  out  1  bus request.
- mem_instr  out  1  instruction-fetch qualifier.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0 for loads.
- mem_rdata  in  32  read data, valid in the mem_ready cycle.

## Operation
- States: IDLE, BUS, RESP. All outputs are registered except cmd_ready, which equals (state == IDLE).
- IDLE: on cmd_valid high, latch the command.
  - Aligned and legal: go to BUS.
  - Otherwise: go to RESP with rsp_error = 1 and rsp_rdata = 0. No bus activity.
- Alignment rules: half requires addr[0] == 0; word requires addr[1:0] == 0; byte is always aligned. cmd_size 3 is an error.
- BUS: mem_valid = 1. mem_addr, mem_wdata, mem_wstrb and mem_instr stay constant until completion.
  - Byte store: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 4'b0001 << addr[1:0].
  - Half store: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 4'b0011 << addr[1:0].
  - Word store: mem_wstrb = 4'b1111.
  - mem_instr = cmd_instr & ~cmd_write.
- Completion: the first cycle with mem_valid and mem_ready both high.
  - Capture mem_rdata. Select lane = mem_rdata >> (8 * addr[1:0]).
  - Take [7:0] or [15:0] of the lane; sign-extend when cmd_signed, else zero-extend.
  - Go to RESP with rsp_error = 0.
- Watchdog: a counter clears on BUS entry and increments each BUS cycle. If the counter reaches TIMEOUT_CYCLES − 1 with mem_ready low, go to RESP with rsp_error = 1 and rsp_rdata = 0. mem_ready in that same cycle wins and completes normally.
- RESP: rsp_valid = 1 and rsp_* stay stable until rsp_ready is high; then return to IDLE.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - mem_valid, rsp_valid, rsp_error and mem_instr drop to 0 immediately.
  - mem_addr, mem_wdata, mem_wstrb and rsp_rdata go to 0.
  - Counter goes to 0.
  - An in-flight transaction is abandoned with no response.

## Timing
- Command accepted at edge N: mem_valid is high from N+1.
- mem_ready sampled at edge M: mem_valid is low and rsp_valid is high from M+1. A responder that checks !mem_ready never sees a double accept.
- Error path: accepted at N, rsp_valid high from N+1.
- rsp_ready sampled at edge R: IDLE and cmd_ready high from R+1.
- Against a one-cycle-registered responder: 4 cycles per command with rsp_ready tied high.
- Timeout: mem_valid is high for exactly TIMEOUT_CYCLES cycles, then rsp_valid rises.
- mem_ready while mem_valid is low is ignored.

## Test plan
- Word store then word load: store 0xDEADBEEF to 0x100, then load 0x100.
  - Store: one cycle with mem_wstrb = 4'hF, mem_addr = 0x100.
  - Load: rsp_rdata = 0xDEADBEEF, rsp_error = 0.
- Byte lanes: memory word 0x80FF7F01 at 0x200.
  - Signed byte load of 0x203 returns 0xFFFFFF80.
  - Unsigned byte load of 0x202 returns 0x000000FF.
  - Byte store of 0xA5 to 0x201 drives mem_wdata = 0xA5A5A5A5, mem_wstrb = 4'b0010.
- Misaligned and illegal: half load at 0x101 and word store at 0x102 each return rsp_error = 1 one cycle after acceptance, with mem_valid never high. cmd_size = 3 behaves the same.
- Timeout with TIMEOUT_CYCLES = 8 and mem_ready held low: mem_valid is high exactly 8 cycles, then rsp_error = 1. With mem_ready in the 8th cycle, completion is normal with rsp_error = 0.
- Backpressure: rsp_ready low for 5 cycles. rsp_valid, rsp_rdata and rsp_error hold; cmd_ready stays 0; no second mem_valid appears.
- Reset mid-BUS: resetn low between edges. mem_valid and rsp_valid read 0 before the next edge. After release, cmd_ready = 1 and the next command runs normally.

Source files
------------

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
//
// Command-driven initiator for the picorv32 native memory interface. Accepts
// one load/store command at a time and turns it into a single word-aligned
// bus transaction with byte strobes. Load data comes back right-aligned and
// sign- or zero-extended. A per-transaction watchdog ends a bus request that
// no responder answers.
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles mem_valid is held awaiting mem_ready
//                   (legal range 1 .. 2^20)
//
// Ports
//   clk, resetn     clock (rising edge) and asynchronous active-low reset
//   cmd_valid       command offered
//   cmd_ready       command accepted this cycle (high only in IDLE)
//   cmd_write       1 = store, 0 = load
//   cmd_instr       instruction-fetch qualifier, loads only
//   cmd_size        0 = byte, 1 = half, 2 = word, 3 = illegal
//   cmd_signed      sign-extend load data (byte/half loads only)
//   cmd_addr        byte address
//   cmd_wdata       store data, right-aligned
//   rsp_valid       response available (held until rsp_ready)
//   rsp_ready       response consumed
//   rsp_rdata       extended load data; 0 for stores and errors
//   rsp_error       misaligned, illegal size or timeout
//   mem_valid       bus request
//   mem_instr       instruction-fetch qualifier on the bus
//   mem_ready       responder completion
//   mem_addr        word address, bits [1:0] always 0
//   mem_wdata       lane-replicated store data
//   mem_wstrb       byte strobes, 0 for loads
//   mem_rdata       read data, valid in the mem_ready cycle
// -----------------------------------------------------------------------------
module mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_instr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_signed,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // 21 bits holds TIMEOUT_CYCLES - 1 for the full legal range up to 2^20.
    localparam int unsigned        CNT_W    = 21;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic             write_q,     write_d;
    logic             signed_q,    signed_d;
    logic [1:0]       size_q,      size_d;
    logic [1:0]       lane_q,      lane_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             mem_valid_q, mem_valid_d;
    logic             mem_instr_q, mem_instr_d;
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_error_q, rsp_error_d;

    // -------------------------------------------------------------------------
    // Command decode: legality/alignment and store lane formatting
    // -------------------------------------------------------------------------
    logic        cmd_ok;
    logic [31:0] cmd_bus_wdata;
    logic [3:0]  cmd_bus_wstrb;

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_size)
            SZ_BYTE: cmd_ok = 1'b1;
            SZ_HALF: cmd_ok = ~cmd_addr[0];
            SZ_WORD: cmd_ok = (cmd_addr[1:0] == 2'b00);
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        cmd_bus_wdata = cmd_wdata;
        cmd_bus_wstrb = 4'b1111;
        case (cmd_size)
            SZ_BYTE: begin
                cmd_bus_wdata = {4{cmd_wdata[7:0]}};
                cmd_bus_wstrb = 4'b0001 << cmd_addr[1:0];
            end
            SZ_HALF: begin
                cmd_bus_wdata = {2{cmd_wdata[15:0]}};
                cmd_bus_wstrb = 4'b0011 << cmd_addr[1:0];
            end
            default: begin
                cmd_bus_wdata = cmd_wdata;
                cmd_bus_wstrb = 4'b1111;
            end
        endcase
        if (!cmd_write) begin
            cmd_bus_wstrb = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Load data extraction: shift the addressed lane down, then extend
    // -------------------------------------------------------------------------
    logic [31:0] lane_data;
    logic [31:0] load_data;

    always_comb begin
        lane_data = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & lane_data[7]}},  lane_data[7:0]};
            SZ_HALF: load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d  = cmd_write;
                    signed_d = cmd_signed;
                    size_d   = cmd_size;
                    lane_d   = cmd_addr[1:0];
                    cnt_d    = '0;
                    if (cmd_ok) begin
                        state_d     = S_BUS;
                        mem_valid_d = 1'b1;
                        mem_instr_d = cmd_instr & ~cmd_write;
                        mem_addr_d  = {cmd_addr[31:2], 2'b00};
                        mem_wdata_d = cmd_bus_wdata;
                        mem_wstrb_d = cmd_bus_wstrb;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end

            S_BUS: begin
                // mem_ready wins over the watchdog when both land together.
                if (mem_ready) begin
                    state_d     = S_RESP;
                    mem_valid_d = 1'b0;
                    mem_instr_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = write_q ? '0 : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    mem_valid_d = 1'b0;
                    mem_instr_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
                mem_instr_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_initiator
//
// Directed bench for mem_initiator. A small word memory answers the bus after
// a programmable number of mem_valid cycles; a table of commands with
// hand-computed results is applied in order, followed by hand-written
// sequences for watchdog, response backpressure and reset mid-transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_initiator;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_instr, cmd_signed;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_instr  (cmd_instr),
        .cmd_size   (cmd_size),
        .cmd_signed (cmd_signed),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // Responder memory and bus monitor
    // -------------------------------------------------------------------------
    logic [31:0] mem [0:255];
    int          resp_delay = 1;
    int          vcnt = 0;
    int          mv_cycles = 0;
    int          cap_count = 0;
    int          unstable = 0;
    logic        preload_done = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        cap_instr = 1'b0;
    logic        prev_valid = 1'b0;
    logic [68:0] prev_bus = '0;

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 256; i++) mem[i] = '0;
            mem[8'h80] = 32'h80FF7F01;
            preload_done = 1'b1;
        end
        if (mem_valid) mv_cycles++;
        if (mem_valid && prev_valid && ({mem_addr, mem_wdata, mem_wstrb, mem_instr} !== prev_bus))
            unstable++;
        prev_valid = mem_valid;
        prev_bus   = {mem_addr, mem_wdata, mem_wstrb, mem_instr};
        if (mem_valid && mem_ready) begin
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_wstrb = mem_wstrb;
            cap_instr = mem_instr;
            cap_count++;
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_ready <= 1'b0;
            vcnt = 0;
        end else if (mem_valid) begin
            vcnt++;
            if (vcnt == resp_delay) begin
                mem_ready <= 1'b1;
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end else begin
            vcnt = 0;
            mem_ready <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic        instr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_mv;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_wstrb;
        logic        exp_instr;
    } vec_t;

    vec_t vq[$];

    task automatic run_cmd(input vec_t v, input string nm);
        int mv0, cap0, uns0, waitc;
        @(negedge clk);
        check({nm, "_cmd_ready"}, cmd_ready, 1);
        cmd_write  = v.write;
        cmd_instr  = v.instr;
        cmd_size   = v.size;
        cmd_signed = v.sgn;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_valid  = 1'b1;
        rsp_ready  = 1'b1;
        mv0  = mv_cycles;
        cap0 = cap_count;
        uns0 = unstable;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitc = 1;
        while (rsp_valid !== 1'b1 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        check({nm, "_rsp_valid"}, rsp_valid, 1);
        check({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({nm, "_error"}, rsp_error, v.exp_err);
        check({nm, "_mv_cycles"}, mv_cycles - mv0, v.exp_mv);
        check({nm, "_completions"}, cap_count - cap0, v.exp_err ? 0 : 1);
        if (v.exp_mv == 0) check({nm, "_err_latency"}, waitc, 1);
        else               check({nm, "_bus_stable"}, unstable - uns0, 0);
        if (!v.exp_err) begin
            check({nm, "_maddr"}, cap_addr, v.exp_maddr);
            check({nm, "_wstrb"}, cap_wstrb, v.exp_wstrb);
            check({nm, "_minstr"}, cap_instr, v.exp_instr);
            if (v.write) check({nm, "_mwdata"}, cap_wdata, v.exp_mwdata);
        end
        @(negedge clk);
        check({nm, "_rsp_done"}, rsp_valid, 0);
        check({nm, "_idle"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t bp;
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_instr = 1'b0; cmd_size = '0;
        cmd_signed = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_mem_instr", mem_instr, 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        resetn = 1'b1;

        // write instr size sgn addr wdata | rdata err mv maddr mwdata wstrb instr
        vq.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd2, 1'b1, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h100, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 32'h202, 32'h0,        32'h000000FF, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 32'h202, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 32'h201, 32'h0,        32'h0000007F, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0,        32'h000080FF, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        32'hFFFF80FF, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 32'h200, 32'h0,        32'h00007F01, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b1});
        vq.push_back('{1'b1, 1'b1, 2'd0, 1'b0, 32'h201, 32'h123456A5, 32'h0,        1'b0, 2, 32'h200, 32'hA5A5A5A5, 4'h2, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'h80FFA501, 1'b0, 2, 32'h200, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'hFFFFBEEF, 32'h0,        1'b0, 2, 32'h100, 32'hBEEFBEEF, 4'hC, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 32'h100, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'h0000BEEF, 1'b0, 2, 32'h100, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h00000011, 32'h0,        1'b0, 2, 32'h100, 32'h11111111, 4'h8, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h11EFBEEF, 1'b0, 2, 32'h100, 32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 0, 32'h0,   32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'hCAFEF00D, 32'h0,        1'b1, 0, 32'h0,   32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 0, 32'h0,   32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 2'd2, 1'b1, 32'h203, 32'h0,        32'h0,        1'b1, 0, 32'h0,   32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h203, 32'h00001234, 32'h0,        1'b1, 0, 32'h0,   32'h0,        4'h0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h00000011, 1'b0, 2, 32'h100, 32'h0,        4'h0, 1'b0});

        foreach (vq[i]) run_cmd(vq[i], $sformatf("v%0d", i));

        // Watchdog: no answer, answer in the last allowed cycle, answer one too late.
        resp_delay = 1000;
        run_cmd('{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 8, 32'h0, 32'h0, 4'h0, 1'b0}, "to_none");
        resp_delay = 7;
        run_cmd('{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h11EFBEEF, 1'b0, 8, 32'h100, 32'h0, 4'h0, 1'b0}, "to_last");
        resp_delay = 8;
        run_cmd('{1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h55AA55AA, 32'h0, 1'b1, 8, 32'h0, 32'h0, 4'h0, 1'b0}, "to_late");
        resp_delay = 1;
        run_cmd('{1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 2, 32'h300, 32'h0, 4'h0, 1'b0}, "to_nowrite");

        // Backpressure: response held 5 cycles while another command waits.
        begin
            int mv0, waitc;
            @(negedge clk);
            cmd_write = 1'b0; cmd_instr = 1'b0; cmd_size = 2'd1; cmd_signed = 1'b1;
            cmd_addr = 32'h202; cmd_wdata = '0; cmd_valid = 1'b1; rsp_ready = 1'b0;
            mv0 = mv_cycles;
            waitc = 0;
            @(negedge clk);
            while (rsp_valid !== 1'b1 && waitc < 60) begin
                @(negedge clk);
                waitc++;
            end
            check("bp_rsp_seen", rsp_valid, 1);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("bp_hold_valid_%0d", c), rsp_valid, 1);
                check($sformatf("bp_hold_rdata_%0d", c), rsp_rdata, 32'hFFFF80FF);
                check($sformatf("bp_hold_error_%0d", c), rsp_error, 0);
                check($sformatf("bp_hold_cmdrdy_%0d", c), cmd_ready, 0);
            end
            check("bp_single_request", mv_cycles - mv0, 2);
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            check("bp_release_idle", cmd_ready, 1);
            check("bp_release_valid", rsp_valid, 0);
        end

        // Reset asserted between edges while mem_valid is high.
        resp_delay = 1000;
        @(negedge clk);
        cmd_write = 1'b0; cmd_size = 2'd2; cmd_signed = 1'b0; cmd_addr = 32'h200;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstbus_pre_valid", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("rstbus_mem_valid", mem_valid, 0);
        check("rstbus_rsp_valid", rsp_valid, 0);
        check("rstbus_cmd_ready", cmd_ready, 1);
        check("rstbus_mem_addr",  mem_addr, 0);
        check("rstbus_mem_wstrb", mem_wstrb, 0);
        @(negedge clk);
        resetn = 1'b1;
        resp_delay = 1;
        run_cmd('{1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h80FFA501, 1'b0, 2, 32'h200, 32'h0, 4'h0, 1'b0}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
